// File: rtl/wb_pkg.sv
// Shared encodings and stage-entry control type for the write-back tracker.
package wb_pkg;

    // Destination-kind encodings seen at D
    localparam logic [1:0] DST_NONE = 2'd0;
    localparam logic [1:0] DST_RT   = 2'd1;
    localparam logic [1:0] DST_RD   = 2'd2;
    localparam logic [1:0] DST_LINK = 2'd3;

    // Result-source encodings; code 3 behaves as ALU
    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_LINK = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;

    // Width-independent part of a stage entry; dst and value are
    // parametrised in the top and kept alongside this struct.
    typedef struct packed {
        logic       valid;
        logic [1:0] src;
    } entry_ctl_t;

    // Fold the unused source code onto ALU so stages only ever hold 0..2
    function automatic logic [1:0] src_norm(input logic [1:0] src);
        logic [1:0] res;
        case (src)
            SRC_LINK: res = SRC_LINK;
            SRC_MEM:  res = SRC_MEM;
            default:  res = SRC_ALU;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_fwd_port.sv
// Priority forwarding match for one D-stage read port (E over M over W).
module wb_fwd_port
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            e_valid,
    input  logic [RA_W-1:0] e_dst,
    input  logic [1:0]      e_src,
    input  logic [XLEN-1:0] e_data,
    input  logic            m_valid,
    input  logic [RA_W-1:0] m_dst,
    input  logic [XLEN-1:0] m_data,
    input  logic            w_valid,
    input  logic [RA_W-1:0] w_dst,
    input  logic [XLEN-1:0] w_data,
    output logic [XLEN-1:0] data,
    output logic            hazard
);

    // Youngest matching stage wins; a load still in E cannot supply data yet
    always_comb begin
        data   = rf_data;
        hazard = 1'b0;
        if (addr == {RA_W{1'b0}}) begin
            data = {XLEN{1'b0}};
        end else if (e_valid && (e_dst == addr)) begin
            data   = e_data;
            hazard = (e_src == SRC_MEM);
        end else if (m_valid && (m_dst == addr)) begin
            data = m_data;
        end else if (w_valid && (w_dst == addr)) begin
            data = w_data;
        end else begin
            data = rf_data;
        end
    end

endmodule

// File: rtl/wb_track.sv
// Tracks destination and result of in-flight instructions through E/M/W,
// forwards operands to D read ports, detects load-use and drives RF write.
module wb_track
    import wb_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned LINK_OFS = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                d_valid,
    input  logic [1:0]          d_dst_kind,
    input  logic [RA_W-1:0]     d_rt,
    input  logic [RA_W-1:0]     d_rd,
    input  logic [1:0]          d_src,
    input  logic [XLEN-1:0]     d_pc,
    input  logic                flush,
    input  logic [XLEN-1:0]     e_alu_result,
    input  logic [XLEN-1:0]     m_mem_data,
    input  logic [NRD*RA_W-1:0] rd_addr,
    input  logic [NRD*XLEN-1:0] rd_rf_data,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic                stall,
    output logic                w_we,
    output logic [RA_W-1:0]     w_addr,
    output logic [XLEN-1:0]     w_data
);

    localparam logic [RA_W-1:0] LINK_ADDR = RA_W'(LINK_REG);
    localparam logic [XLEN-1:0] LINK_ADD  = XLEN'(LINK_OFS);

    entry_ctl_t      e_ctl_r, m_ctl_r, w_ctl_r;
    logic [RA_W-1:0] e_dst_r, m_dst_r, w_dst_r;
    logic [XLEN-1:0] e_val_r, m_val_r, w_val_r;

    logic [RA_W-1:0] d_dst_s;
    logic [1:0]      d_src_s;
    logic            bubble_s;
    logic [XLEN-1:0] e_avail_s;
    logic [XLEN-1:0] m_avail_s;
    logic [NRD-1:0]  haz_s;

    assign d_src_s  = src_norm(d_src);
    assign bubble_s = stall || flush || !d_valid;

    // Decode the destination register named by the D instruction
    always_comb begin
        d_dst_s = {RA_W{1'b0}};
        case (d_dst_kind)
            DST_NONE: d_dst_s = {RA_W{1'b0}};
            DST_RT:   d_dst_s = d_rt;
            DST_RD:   d_dst_s = d_rd;
            DST_LINK: d_dst_s = LINK_ADDR;
            default:  d_dst_s = {RA_W{1'b0}};
        endcase
    end

    // Data each younger stage can offer this cycle (loads in E offer nothing)
    always_comb begin
        e_avail_s = {XLEN{1'b0}};
        case (e_ctl_r.src)
            SRC_LINK: e_avail_s = e_val_r;
            SRC_ALU:  e_avail_s = e_alu_result;
            default:  e_avail_s = {XLEN{1'b0}};
        endcase
        if (m_ctl_r.src == SRC_MEM) begin
            m_avail_s = m_mem_data;
        end else begin
            m_avail_s = m_val_r;
        end
    end

    // Advance entries D->E->M->W, capturing each result where it becomes valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_ctl_r <= '0;
            m_ctl_r <= '0;
            w_ctl_r <= '0;
            e_dst_r <= {RA_W{1'b0}};
            m_dst_r <= {RA_W{1'b0}};
            w_dst_r <= {RA_W{1'b0}};
            e_val_r <= {XLEN{1'b0}};
            m_val_r <= {XLEN{1'b0}};
            w_val_r <= {XLEN{1'b0}};
        end else begin
            if (bubble_s) begin
                e_ctl_r <= '0;
                e_dst_r <= {RA_W{1'b0}};
                e_val_r <= {XLEN{1'b0}};
            end else begin
                e_ctl_r <= '{valid: 1'b1, src: d_src_s};
                e_dst_r <= d_dst_s;
                e_val_r <= (d_src_s == SRC_LINK) ? (d_pc + LINK_ADD) : {XLEN{1'b0}};
            end
            m_ctl_r <= e_ctl_r;
            m_dst_r <= e_dst_r;
            m_val_r <= (e_ctl_r.src == SRC_ALU) ? e_alu_result : e_val_r;
            w_ctl_r <= m_ctl_r;
            w_dst_r <= m_dst_r;
            w_val_r <= (m_ctl_r.src == SRC_MEM) ? m_mem_data : m_val_r;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        wb_fwd_port #(
            .XLEN(XLEN),
            .RA_W(RA_W)
        ) u_port (
            .addr    (rd_addr[i*RA_W +: RA_W]),
            .rf_data (rd_rf_data[i*XLEN +: XLEN]),
            .e_valid (e_ctl_r.valid),
            .e_dst   (e_dst_r),
            .e_src   (e_ctl_r.src),
            .e_data  (e_avail_s),
            .m_valid (m_ctl_r.valid),
            .m_dst   (m_dst_r),
            .m_data  (m_avail_s),
            .w_valid (w_ctl_r.valid),
            .w_dst   (w_dst_r),
            .w_data  (w_val_r),
            .data    (rd_data[i*XLEN +: XLEN]),
            .hazard  (haz_s[i])
        );
    end

    assign stall  = |haz_s;
    assign w_we   = w_ctl_r.valid && (w_dst_r != {RA_W{1'b0}});
    assign w_addr = w_dst_r;
    assign w_data = w_val_r;

endmodule

// File: tb/tb_wb_track.sv
// Directed self-checking bench for wb_track.
module tb_wb_track;

    logic        clk;
    logic        reset_n;
    logic        d_valid;
    logic [1:0]  d_dst_kind;
    logic [4:0]  d_rt, d_rd;
    logic [1:0]  d_src;
    logic [31:0] d_pc;
    logic        flush;
    logic [31:0] e_alu_result;
    logic [31:0] m_mem_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_rf_data;
    logic [63:0] rd_data;
    logic        stall;
    logic        w_we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hAAAA_0001;

    wb_track dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_dst_kind(d_dst_kind),
        .d_rt(d_rt), .d_rd(d_rd), .d_src(d_src), .d_pc(d_pc), .flush(flush),
        .e_alu_result(e_alu_result), .m_mem_data(m_mem_data), .rd_addr(rd_addr),
        .rd_rf_data(rd_rf_data), .rd_data(rd_data), .stall(stall), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [1:0] src, input logic [31:0] pc);
        d_valid = 1'b1; d_dst_kind = kind; d_rt = rt; d_rd = rd; d_src = src; d_pc = pc;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_dst_kind = 2'd0; d_rt = 5'd0; d_rd = 5'd0; d_src = 2'd0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; d_pc = 32'd0; idle();
        e_alu_result = 32'd0; m_mem_data = 32'd0;
        rd_rf_data = {RF1, RF0};
        rd_addr = {5'd3, 5'd0};
        #1;
        // reset state
        chk("rst_we", {31'd0, w_we}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rd0_zero", rd_data[31:0], 32'd0);
        chk("rst_rd1_rf", rd_data[63:32], RF1);
        @(negedge clk); reset_n = 1'b1;
        tick();
        chk("idle_we", {31'd0, w_we}, 32'd0);

        // ALU chain: addu -> $8
        issue(2'd2, 5'd1, 5'd8, 2'd0, 32'h0000_1000); rd_addr = 10'd0;
        tick();
        idle(); rd_addr = {5'd8, 5'd8}; e_alu_result = 32'h10; #1;
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk("alu_fwd_e0", rd_data[31:0], 32'h10);
        chk("alu_fwd_e1", rd_data[63:32], 32'h10);
        tick();
        e_alu_result = 32'h99; #1;
        chk("alu_fwd_m", rd_data[31:0], 32'h10);
        tick();
        chk("alu_we", {31'd0, w_we}, 32'd1);
        chk("alu_waddr", {27'd0, w_addr}, 32'd8);
        chk("alu_wdata", w_data, 32'h10);
        chk("alu_fwd_w", rd_data[31:0], 32'h10);
        tick();
        chk("alu_drain", {31'd0, w_we}, 32'd0);

        // Load-use: lw -> $9, next reads $9
        issue(2'd1, 5'd9, 5'd0, 2'd2, 32'h0000_2000); rd_addr = 10'd0;
        tick();
        issue(2'd0, 5'd0, 5'd0, 2'd0, 32'h0000_2004); rd_addr = {5'd0, 5'd9}; #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        m_mem_data = 32'hCAFE_F00D; #1;
        chk("lu_stall_off", {31'd0, stall}, 32'd0);
        chk("lu_fwd_m", rd_data[31:0], 32'hCAFE_F00D);
        tick();
        idle(); rd_addr = 10'd0; #1;
        chk("lu_we", {31'd0, w_we}, 32'd1);
        chk("lu_waddr", {27'd0, w_addr}, 32'd9);
        chk("lu_wdata", w_data, 32'hCAFE_F00D);
        tick(); tick();

        // Link: jal at 0x3000
        issue(2'd3, 5'd0, 5'd0, 2'd1, 32'h0000_3000);
        tick();
        idle(); rd_addr = {5'd0, 5'd31}; e_alu_result = 32'h5555_5555; #1;
        chk("link_fwd_e", rd_data[31:0], 32'h0000_3008);
        chk("link_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("link_fwd_m", rd_data[31:0], 32'h0000_3008);
        tick();
        chk("link_we", {31'd0, w_we}, 32'd1);
        chk("link_waddr", {27'd0, w_addr}, 32'd31);
        chk("link_wdata", w_data, 32'h0000_3008);

        // Link wrap-around
        issue(2'd3, 5'd0, 5'd0, 2'd1, 32'hFFFF_FFFC);
        tick();
        idle(); #1;
        chk("link_wrap", rd_data[31:0], 32'h0000_0004);
        tick(); tick(); tick();

        // Priority: E and W both target $5
        issue(2'd2, 5'd0, 5'd5, 2'd0, 32'h0000_4000); rd_addr = 10'd0;
        tick();
        idle(); e_alu_result = 32'h2;
        tick();
        issue(2'd2, 5'd0, 5'd5, 2'd0, 32'h0000_4008);
        tick();
        idle(); e_alu_result = 32'h1; rd_addr = {5'd0, 5'd5}; #1;
        chk("prio_e_over_w", rd_data[31:0], 32'h1);
        chk("prio_w_we", {31'd0, w_we}, 32'd1);
        chk("prio_w_data", w_data, 32'h2);
        tick(); tick(); tick();

        // Write to $0 and read of $0
        issue(2'd2, 5'd0, 5'd0, 2'd0, 32'h0000_5000); rd_addr = {5'd0, 5'd0};
        tick();
        idle(); e_alu_result = 32'h77; #1;
        chk("zero_rd1", rd_data[63:32], 32'd0);
        tick(); tick();
        chk("zero_we", {31'd0, w_we}, 32'd0);
        tick();

        // Flush: addu -> $4 squashed
        issue(2'd2, 5'd0, 5'd4, 2'd0, 32'h0000_6000); flush = 1'b1; e_alu_result = 32'h44;
        tick();
        flush = 1'b0; idle(); rd_addr = {5'd0, 5'd4}; #1;
        chk("flush_nofwd", rd_data[31:0], RF0);
        tick();
        chk("flush_we_m", {31'd0, w_we}, 32'd0);
        tick();
        chk("flush_we_w", {31'd0, w_we}, 32'd0);

        // Mid-stream reset discards in-flight entry
        issue(2'd2, 5'd0, 5'd7, 2'd0, 32'h0000_7000); rd_addr = {5'd0, 5'd7}; e_alu_result = 32'h70;
        tick();
        idle();
        tick();
        chk("mrst_pre_fwd", rd_data[31:0], 32'h70);
        #2 reset_n = 1'b0; #1;
        chk("mrst_we", {31'd0, w_we}, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        chk("mrst_rd0_rf", rd_data[31:0], RF0);
        @(negedge clk); reset_n = 1'b1;
        tick();
        chk("mrst_post1", {31'd0, w_we}, 32'd0);
        tick();
        chk("mrst_post2", {31'd0, w_we}, 32'd0);
        chk("mrst_post_rd0", rd_data[31:0], RF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
